// File: rtl/veda_frame_sequencer.sv
// -----------------------------------------------------------------------------
// veda_frame_sequencer
//
// Streaming front end for the 32x32 Veda memory. A frame arrives on a
// valid/ready input stream. Each word is written to the next address while the
// memory is in scribble mode (mem_mode=0). The memory is then switched to
// interpret mode (mem_mode=1), and the frame is read back in order and sent out
// on a valid/ready output stream.
//
// Parameters
//   DEPTH     words per frame (maximum); equals the memory depth
//   ADDR_W    memory address width; DEPTH == 2**ADDR_W
//   READ_LAT  cycles from a mem_address_b update to valid mem_data_out (0..3)
//
// Ports
//   clk, reset                  clock; asynchronous active-low reset
//   in_valid/in_ready/in_data/in_last      input frame stream
//   out_valid/out_ready/out_data/out_last  read-back frame stream
//   mem_address_a/mem_data_in/mem_write_enable  memory write port
//   mem_address_b/mem_data_out                  memory read port
//   mem_mode                    0 = scribble, 1 = interpret
//   frame_count                 words stored in the current frame
//   trunc                       sticky: the frame filled DEPTH without in_last
// -----------------------------------------------------------------------------
module veda_frame_sequencer #(
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic              out_last,
  output logic [ADDR_W-1:0] mem_address_a,
  output logic [ADDR_W-1:0] mem_address_b,
  output logic [31:0]       mem_data_in,
  output logic              mem_write_enable,
  output logic              mem_mode,
  input  logic [31:0]       mem_data_out,
  output logic [ADDR_W:0]   frame_count,
  output logic              trunc
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WRITE   = 3'd1;
  localparam logic [2:0] S_FLUSH   = 3'd2;
  localparam logic [2:0] S_RD_ADDR = 3'd3;
  localparam logic [2:0] S_RD_WAIT = 3'd4;
  localparam logic [2:0] S_RD_OUT  = 3'd5;

  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
  // Final RD_WAIT cycle; unused when READ_LAT is 0.
  localparam logic [1:0]        WAIT_LAST = 2'((READ_LAT > 0) ? READ_LAT - 1 : 0);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   frame_count_q, frame_count_d;
  logic              trunc_q, trunc_d;
  logic [1:0]        wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0] addr_a_q, addr_a_d;
  logic [ADDR_W-1:0] addr_b_q, addr_b_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              mode_q, mode_d;
  logic [31:0]       out_data_q, out_data_d;
  logic              out_last_q, out_last_d;

  logic in_fire;
  logic out_fire;
  logic frame_end;
  logic capture;

  assign in_ready  = (state_q == S_WRITE);
  assign out_valid = (state_q == S_RD_OUT);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  // A frame closes on in_last, or when the word for the final address arrives.
  assign frame_end = in_last || (wr_ptr_q == LAST_ADDR);
  // Read data is captured on the edge that leaves the address/wait phase.
  assign capture   = ((state_q == S_RD_ADDR) && (READ_LAT == 0)) ||
                     ((state_q == S_RD_WAIT) && (wait_cnt_q == WAIT_LAST));

  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    frame_count_d = frame_count_q;
    trunc_d       = trunc_q;
    wait_cnt_d    = wait_cnt_q;
    addr_a_d      = addr_a_q;
    addr_b_d      = addr_b_q;
    wdata_d       = wdata_q;
    we_d          = 1'b0;
    out_data_d    = out_data_q;
    out_last_d    = out_last_q;

    case (state_q)
      S_IDLE: begin
        state_d       = S_WRITE;
        wr_ptr_d      = '0;
        rd_ptr_d      = '0;
        frame_count_d = '0;
        trunc_d       = 1'b0;
      end
      S_WRITE: begin
        if (in_fire) begin
          we_d          = 1'b1;
          addr_a_d      = wr_ptr_q;
          wdata_d       = in_data;
          frame_count_d = frame_count_q + CNT_ONE;
          if (frame_end) begin
            state_d = S_FLUSH;
            trunc_d = !in_last;
          end else begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
          end
        end
      end
      // One spare cycle lets the final write strobe complete while mode is 0.
      S_FLUSH: begin
        state_d  = S_RD_ADDR;
        addr_b_d = rd_ptr_q;
      end
      S_RD_ADDR: begin
        wait_cnt_d = '0;
        state_d    = (READ_LAT == 0) ? S_RD_OUT : S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          state_d = S_RD_OUT;
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
      end
      S_RD_OUT: begin
        if (out_fire) begin
          if (out_last_q) begin
            state_d = S_IDLE;
          end else begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            addr_b_d = rd_ptr_q + PTR_ONE;
            state_d  = S_RD_ADDR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (capture) begin
      out_data_d = mem_data_out;
      out_last_d = ({1'b0, rd_ptr_q} == (frame_count_q - CNT_ONE));
    end

    // Mode follows the next state, so it rises on the same edge that ends the
    // last write strobe.
    mode_d = (state_d == S_RD_ADDR) || (state_d == S_RD_WAIT) || (state_d == S_RD_OUT);
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops
  // sample the pre-edge values consistently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      frame_count_q <= '0;
      trunc_q       <= 1'b0;
      wait_cnt_q    <= '0;
      addr_a_q      <= '0;
      addr_b_q      <= '0;
      wdata_q       <= '0;
      we_q          <= 1'b0;
      mode_q        <= 1'b0;
      out_data_q    <= '0;
      out_last_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      frame_count_q <= frame_count_d;
      trunc_q       <= trunc_d;
      wait_cnt_q    <= wait_cnt_d;
      addr_a_q      <= addr_a_d;
      addr_b_q      <= addr_b_d;
      wdata_q       <= wdata_d;
      we_q          <= we_d;
      mode_q        <= mode_d;
      out_data_q    <= out_data_d;
      out_last_q    <= out_last_d;
    end
  end

  assign mem_address_a    = addr_a_q;
  assign mem_address_b    = addr_b_q;
  assign mem_data_in      = wdata_q;
  assign mem_write_enable = we_q;
  assign mem_mode         = mode_q;
  assign out_data         = out_data_q;
  assign out_last         = out_last_q;
  assign frame_count      = frame_count_q;
  assign trunc            = trunc_q;

endmodule

// File: tb/tb_veda_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_veda_frame_sequencer
//
// Three sequencers share one input stream and reset. Each one has its own
// behavioural Veda memory:
//   index 0: READ_LAT=1, output stream driven and scored in detail
//   index 1: READ_LAT=0, output always ready, words logged
//   index 2: READ_LAT=3, output always ready, words logged
// The reference model is a frame-level queue. Accepted words are grouped into
// frames that close on in_last or at DEPTH words, and each frame is expected
// back in order with the last flag on its final word.
// -----------------------------------------------------------------------------
module tb_veda_frame_sequencer;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;
  localparam int NDUT   = 3;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } word_t;

  logic clk = 1'b0;
  logic reset;
  logic in_valid;
  logic in_last;
  logic [31:0] in_data;
  logic out_ready_m;

  logic [NDUT-1:0]             in_ready;
  logic [NDUT-1:0]             out_valid;
  logic [NDUT-1:0]             out_last;
  logic [NDUT-1:0]             we;
  logic [NDUT-1:0]             mode;
  logic [NDUT-1:0]             trunc;
  logic [NDUT-1:0][31:0]       out_data;
  logic [NDUT-1:0][31:0]       din;
  logic [NDUT-1:0][31:0]       dout;
  logic [NDUT-1:0][ADDR_W-1:0] addr_a;
  logic [NDUT-1:0][ADDR_W-1:0] addr_b;
  logic [NDUT-1:0][ADDR_W:0]   fc;

  always #5 clk = ~clk;

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    localparam int LAT = (k == 0) ? 1 : ((k == 1) ? 0 : 3);
    veda_frame_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .READ_LAT(LAT)) u_dut (
      .clk              (clk),
      .reset            (reset),
      .in_valid         (in_valid),
      .in_ready         (in_ready[k]),
      .in_data          (in_data),
      .in_last          (in_last),
      .out_valid        (out_valid[k]),
      .out_ready        ((k == 0) ? out_ready_m : 1'b1),
      .out_data         (out_data[k]),
      .out_last         (out_last[k]),
      .mem_address_a    (addr_a[k]),
      .mem_address_b    (addr_b[k]),
      .mem_data_in      (din[k]),
      .mem_write_enable (we[k]),
      .mem_mode         (mode[k]),
      .mem_data_out     (dout[k]),
      .frame_count      (fc[k]),
      .trunc            (trunc[k])
    );
  end

  // Behavioural memories: the memory writes only in scribble mode, and read data
  // trails the read address by that instance's latency.
  logic [31:0] mem  [NDUT][DEPTH];
  logic [31:0] pipe [NDUT][3];

  always @(posedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      if (we[k] && !mode[k]) mem[k][addr_a[k]] <= din[k];
      pipe[k][0] <= mem[k][addr_b[k]];
      pipe[k][1] <= pipe[k][0];
      pipe[k][2] <= pipe[k][1];
    end
  end

  assign dout[0] = pipe[0][0];
  assign dout[1] = mem[1][addr_b[1]];
  assign dout[2] = pipe[2][2];

  // With out_ready tied high, every out_valid cycle of these two is a transfer.
  word_t log_lat0[$];
  word_t log_lat3[$];
  always @(posedge clk) begin
    if (out_valid[1]) log_lat0.push_back({out_last[1], out_data[1]});
    if (out_valid[2]) log_lat3.push_back({out_last[2], out_data[2]});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  int    vectors     = 0;
  int    miscompares = 0;
  word_t exp_q[$];
  int    frame_words = 0;
  int    exp_fc      = 0;
  logic  exp_trunc   = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame-level model: a frame closes on in_last or when it reaches DEPTH words.
  task automatic model_accept(input logic [31:0] d, input logic l);
    word_t w;
    logic  close;
    close       = l || (frame_words == DEPTH - 1);
    w.last      = close;
    w.data      = d;
    exp_q.push_back(w);
    frame_words = frame_words + 1;
    exp_fc      = frame_words;
    exp_trunc   = close && !l;
    if (close) frame_words = 0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    frame_words = 0;
    exp_fc      = 0;
    exp_trunc   = 1'b0;
  endtask

  // Waits, with in_valid low, until every sequencer accepts input. It then
  // presents one word for one edge.
  task automatic send(input logic [31:0] d, input logic l);
    int budget;
    budget   = 0;
    in_valid = 1'b0;
    while (in_ready != {NDUT{1'b1}} && budget < 500) begin
      tick();
      budget++;
    end
    if (budget == 500) check("in_ready_wait", in_ready, {NDUT{1'b1}});
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    tick();
    model_accept(d, l);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Scores main-instance output against the model queue until the queue is empty.
  task automatic drain(input bit stall);
    int    budget;
    word_t e;
    budget = 0;
    while (exp_q.size() > 0 && budget < 3000) begin
      out_ready_m = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (out_valid[0] && out_ready_m) begin
        e = exp_q.pop_front();
        check("out_data", out_data[0], e.data);
        check("out_last", out_last[0], e.last);
      end
      tick();
      budget++;
    end
    out_ready_m = 1'b0;
    if (budget == 3000) check("drain_left", exp_q.size(), 0);
  endtask

  task automatic main_outputs_zero(input string tag);
    check({tag, "_in_ready"},  in_ready,     '0);
    check({tag, "_out_valid"}, out_valid[0], 0);
    check({tag, "_out_data"},  out_data[0],  0);
    check({tag, "_out_last"},  out_last[0],  0);
    check({tag, "_addr_a"},    addr_a[0],    0);
    check({tag, "_addr_b"},    addr_b[0],    0);
    check({tag, "_din"},       din[0],       0);
    check({tag, "_we"},        we[0],        0);
    check({tag, "_mode"},      mode[0],      0);
    check({tag, "_fc"},        fc[0],        0);
    check({tag, "_trunc"},     trunc[0],     0);
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] w;
    int          budget;
    word_t       front;

    // 1: reset held with in_valid high
    reset       = 1'b0;
    in_valid    = 1'b1;
    in_data     = 32'hDEAD_BEEF;
    in_last     = 1'b0;
    out_ready_m = 1'b0;
    repeat (3) tick();
    main_outputs_zero("rst");
    in_valid = 1'b0;
    reset    = 1'b1;
    check("rel_in_ready_idle", in_ready, '0);
    tick();
    check("rel_in_ready_write", in_ready, {NDUT{1'b1}});

    // 2: two-word frame, write pulses, mode switch, read-back
    send(32'h1234_5678, 1'b0);
    check("s2_we0",   we[0],     1);
    check("s2_addr0", addr_a[0], 0);
    check("s2_din0",  din[0],    32'h1234_5678);
    check("s2_mode0", mode[0],   0);
    send(32'h8765_4321, 1'b1);
    check("s2_we1",       we[0],       1);
    check("s2_addr1",     addr_a[0],   1);
    check("s2_din1",      din[0],      32'h8765_4321);
    check("s2_mode1",     mode[0],     0);
    check("s2_in_ready",  in_ready[0], 0);
    check("s2_fc",        fc[0],       exp_fc);
    tick();
    check("s2_we_off",    we[0],       0);
    check("s2_mode_rd",   mode[0],     1);
    check("s2_addr_b",    addr_b[0],   0);
    drain(1'b0);

    // 6: the same frame through READ_LAT=0 and READ_LAT=3
    budget = 0;
    while ((log_lat0.size() < 2 || log_lat3.size() < 2) && budget < 200) begin
      tick();
      budget++;
    end
    check("s6_lat0_n",     log_lat0.size(), 2);
    check("s6_lat3_n",     log_lat3.size(), 2);
    check("s6_lat0_w0",    log_lat0[0], {1'b0, 32'h1234_5678});
    check("s6_lat0_w1",    log_lat0[1], {1'b1, 32'h8765_4321});
    check("s6_lat3_w0",    log_lat3[0], {1'b0, 32'h1234_5678});
    check("s6_lat3_w1",    log_lat3[1], {1'b1, 32'h8765_4321});

    // 3: output stall of 10 cycles on the first word of a random frame
    for (int i = 0; i < 5; i++) send($urandom, (i == 4));
    check("s3_fc", fc[0], exp_fc);
    budget = 0;
    while (!out_valid[0] && budget < 50) begin
      tick();
      budget++;
    end
    front = exp_q[0];
    for (int i = 0; i < 10; i++) begin
      check("s3_hold_valid", out_valid[0], 1);
      check("s3_hold_data",  out_data[0],  front.data);
      check("s3_hold_addrb", addr_b[0],    0);
      tick();
    end
    drain(1'b1);

    // 4: 33 words without in_last; the frame closes at DEPTH
    for (int i = 0; i < DEPTH; i++) begin
      send($urandom, 1'b0);
      check("s4_we",   we[0],     1);
      check("s4_addr", addr_a[0], i);
    end
    check("s4_full_in_ready", in_ready[0], 0);
    check("s4_trunc",         trunc[0],    exp_trunc);
    check("s4_fc",            fc[0],       exp_fc);
    drain(1'b1);
    w = $urandom;
    send(w, 1'b0);
    check("s4_next_addr",  addr_a[0], 0);
    check("s4_next_din",   din[0],    w);
    check("s4_next_trunc", trunc[0],  exp_trunc);
    check("s4_next_fc",    fc[0],     exp_fc);
    send($urandom, 1'b1);

    // 5: reset after the first output word, then a single-word frame
    out_ready_m = 1'b1;
    budget = 0;
    while (!out_valid[0] && budget < 50) begin
      tick();
      budget++;
    end
    front = exp_q.pop_front();
    check("s5_first_data", out_data[0], front.data);
    tick();
    out_ready_m = 1'b0;
    reset       = 1'b0;
    #1;
    model_reset();
    main_outputs_zero("s5_rst");
    #2;
    reset = 1'b1;
    tick();
    send(32'hA5A5_A5A5, 1'b1);
    check("s5_fc", fc[0], exp_fc);
    check("s5_n",  exp_q.size(), 1);
    drain(1'b0);
    repeat (3) tick();
    check("s5_no_extra", out_valid[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
